obstacle_scroller: RTL and testbench
====================================

Name: obstacle_scroller

Overview:
Multi-lane successor to the single obstacle position/game-time counter. It drives NUM_CH obstacle lanes, each with its own position counter and a staggered start offset. A shared scroll step ramps up with difficulty over time. A small game-state machine handles menu, run, pause and game-over, and freezes the score at game over. It sits between the game-control logic (menu/win/lose/pause) and the VGA obstacle renderer.

Parameters:
NUM_CH, 4, number of obstacle lanes
POS_W, 10, position counter width; WRAP_LIMIT+STEP_MAX-1 < 2^POS_W is required
TIME_W, 11, game_time width
WRAP_LIMIT, 680, a lane wraps when its position is >= this value
CH_OFFSET, 170, lane i reload value is i*CH_OFFSET; (NUM_CH-1)*CH_OFFSET < WRAP_LIMIT is required
STEP_INIT, 5, initial scroll step per tick
STEP_MAX, 15, step saturation value
LEVEL_TICKS, 256, ticks per difficulty increment

Ports:
clk  in  1  system clock; the only clock
reset  in  1  synchronous, active-high reset
menuScreen  in  1  menu active; forces IDLE and reloads all counters
playerWon  in  1  win event
playerLost  in  1  lose event
pause  in  1  level-sensitive pause request
tick  in  1  frame/advance enable (tie high to advance every clk)
reset_obj_count  in  NUM_CH  per-lane restart request
obj_position  out  NUM_CH*POS_W  lane i occupies bits [i*POS_W +: POS_W]
wrapped  out  NUM_CH  one-cycle pulse per lane on a natural wrap
game_time  out  TIME_W  elapsed ticks, saturating
step  out  5  current scroll step (zero-extended)
game_state  out  2  0=IDLE, 1=RUN, 2=PAUSE, 3=OVER

Behaviour:
- Outputs are registered; all updates occur on posedge clk.
- Priority order: reset > menuScreen > (playerWon|playerLost) > pause > tick.
- Reload values: obj_position[i]=i*CH_OFFSET; game_time=0; step=STEP_INIT; level counter=0; wrapped=0.
- reset=1: state becomes IDLE and all reload values apply on the next edge. This holds mid-run and in every state.
- menuScreen=1 in any state: next state IDLE with reload values.
- IDLE:
  - Outputs hold their reload values.
  - menuScreen=0 -> RUN on the next edge.
  - No advance occurs in the transition cycle.
- RUN:
  - playerWon|playerLost -> OVER. Both asserted together also goes to OVER.
  - Else pause=1 -> PAUSE, with no advance that cycle.
  - Else, when tick=1, advance as described below.
- Advance, per lane:
  - If reset_obj_count[i]: pos <= 0 and wrapped[i]=0.
  - Else if pos >= WRAP_LIMIT: pos <= 0 and wrapped[i]=1 for this cycle only.
  - Else pos <= pos + step, computed at POS_W+1 bits. Overshoot past WRAP_LIMIT by up to step-1 is legal; that lane wraps on its next tick.
- Advance, shared:
  - game_time increments by 1 per tick and saturates at 2^TIME_W-1.
  - The level counter increments per tick.
  - When the level counter is LEVEL_TICKS-1 on a tick, it returns to 0 and step <= min(step+1, STEP_MAX).
  - A new step value takes effect from the following tick. Lane adds in the ramp cycle use the old step.
- PAUSE:
  - Everything is frozen and tick is ignored.
  - pause=0 -> RUN.
  - playerWon|playerLost -> OVER.
- OVER:
  - obj_position, game_time and step are frozen for score display.
  - tick and pause are ignored.
  - Only menuScreen or reset exits this state.
- wrapped is 0 whenever no advance occurs (tick=0, PAUSE, IDLE, OVER).

Test Plan:
1. Reset, then menuScreen=0, tick=1 every cycle -> lane0 reads 0,5,10,...; reaches 680 after 136 ticks; 0 on tick 137 with wrapped[0]=1 for exactly one cycle. Lane1 starts at 170 and wraps on tick 103.
2. Run 256 ticks -> step=6 from tick 257. Run with LEVEL_TICKS=4 -> step climbs to 15 and holds at 15.
3. Assert pause at game_time=40 for 20 cycles with tick=1 -> state=2; positions and game_time unchanged. Deassert -> advance resumes from game_time=40.
4. playerLost at game_time=300 -> state=3 next cycle; game_time holds 300 across 50 ticks. Then menuScreen=1 -> IDLE with reload values (lane2=340).
5. reset_obj_count=4'b0100 with tick -> lane2=0 next cycle and wrapped[2]=0; other lanes advance by step. Then reset=1 mid-run -> all reload values and IDLE on the next edge.
6. TIME_W=4, tick continuous -> game_time reaches 15 and holds there. playerWon and menuScreen asserted together -> IDLE, not OVER.

Source files
------------

// File: rtl/obstacle_scroller_if.sv
// Control and status bundle between game control, the obstacle scroller and the VGA renderer.
interface obstacle_scroller_if #(
    parameter int NUM_CH = 4,
    parameter int POS_W  = 10,
    parameter int TIME_W = 11
);
    logic                    menuScreen;
    logic                    playerWon;
    logic                    playerLost;
    logic                    pause;
    logic                    tick;
    logic [NUM_CH-1:0]       reset_obj_count;
    logic [NUM_CH*POS_W-1:0] obj_position;
    logic [NUM_CH-1:0]       wrapped;
    logic [TIME_W-1:0]       game_time;
    logic [4:0]              step;
    logic [1:0]              game_state;

    modport master (
        output menuScreen, playerWon, playerLost, pause, tick, reset_obj_count,
        input  obj_position, wrapped, game_time, step, game_state
    );
    modport slave (
        input  menuScreen, playerWon, playerLost, pause, tick, reset_obj_count,
        output obj_position, wrapped, game_time, step, game_state
    );
endinterface

// File: rtl/obstacle_scroller.sv
// Multi-lane obstacle position counters with a difficulty-ramped shared step and a
// menu/run/pause/over game-state machine.
module obstacle_scroller_lane #(
    parameter int POS_W      = 10,
    parameter int WRAP_LIMIT = 680,
    parameter int RELOAD     = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             reload,
    input  logic             adv,
    input  logic             restart,
    input  logic [4:0]       step,
    output logic [POS_W-1:0] pos,
    output logic             wrapped
);
    logic [POS_W-1:0] pos_d, pos_q;
    logic             wrapped_d, wrapped_q;
    logic [POS_W:0]   sum;

    always_comb begin
        sum       = {1'b0, pos_q} + (POS_W+1)'(step);
        pos_d     = pos_q;
        wrapped_d = 1'b0;
        if (reload) begin
            pos_d = POS_W'(RELOAD);
        end else if (adv) begin
            if (restart) begin
                pos_d = '0;
            end else if (pos_q >= POS_W'(WRAP_LIMIT)) begin
                pos_d     = '0;
                wrapped_d = 1'b1;
            end else begin
                // Overshoot past the limit is kept; the lane wraps on its next tick.
                pos_d = POS_W'(sum);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pos_q     <= POS_W'(RELOAD);
            wrapped_q <= 1'b0;
        end else begin
            pos_q     <= pos_d;
            wrapped_q <= wrapped_d;
        end
    end

    assign pos     = pos_q;
    assign wrapped = wrapped_q;
endmodule

module obstacle_scroller #(
    parameter int NUM_CH      = 4,
    parameter int POS_W       = 10,
    parameter int TIME_W      = 11,
    parameter int WRAP_LIMIT  = 680,
    parameter int CH_OFFSET   = 170,
    parameter int STEP_INIT   = 5,
    parameter int STEP_MAX    = 15,
    parameter int LEVEL_TICKS = 256
) (
    input logic               clk,
    input logic               reset,
    obstacle_scroller_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, OVER = 2'd3} state_t;
    localparam int LVL_W = (LEVEL_TICKS > 1) ? $clog2(LEVEL_TICKS) : 1;

    state_t                       state_q;
    logic                         end_game;
    logic                         adv;
    logic [TIME_W-1:0]            time_d, time_q;
    logic [4:0]                   step_d, step_q;
    logic [LVL_W-1:0]             lvl_d, lvl_q;
    logic [NUM_CH-1:0][POS_W-1:0] lane_pos;
    logic [NUM_CH-1:0]            lane_wrap;

    assign end_game = bus.playerWon | bus.playerLost;
    // Advance only in RUN when no higher-priority event claims the cycle.
    assign adv = (state_q == RUN) && !reset && !bus.menuScreen && !end_game &&
                 !bus.pause && bus.tick;

    always_ff @(posedge clk) begin
        if (reset || bus.menuScreen) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE:    state_q <= RUN;
                RUN:     if (end_game) state_q <= OVER;
                         else if (bus.pause) state_q <= PAUSE;
                PAUSE:   if (end_game) state_q <= OVER;
                         else if (!bus.pause) state_q <= RUN;
                OVER:    state_q <= OVER;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        time_d = time_q;
        step_d = step_q;
        lvl_d  = lvl_q;
        if (bus.menuScreen) begin
            time_d = '0;
            step_d = 5'(STEP_INIT);
            lvl_d  = '0;
        end else if (adv) begin
            if (time_q != '1) time_d = time_q + TIME_W'(1);
            // The new step is registered here and first used by the lanes on the next tick.
            if (lvl_q == LVL_W'(LEVEL_TICKS - 1)) begin
                lvl_d = '0;
                if (step_q < 5'(STEP_MAX)) step_d = step_q + 5'd1;
            end else begin
                lvl_d = lvl_q + LVL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            time_q <= '0;
            step_q <= 5'(STEP_INIT);
            lvl_q  <= '0;
        end else begin
            time_q <= time_d;
            step_q <= step_d;
            lvl_q  <= lvl_d;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        obstacle_scroller_lane #(
            .POS_W     (POS_W),
            .WRAP_LIMIT(WRAP_LIMIT),
            .RELOAD    (i * CH_OFFSET)
        ) u_lane (
            .clk    (clk),
            .reset  (reset),
            .reload (bus.menuScreen),
            .adv    (adv),
            .restart(bus.reset_obj_count[i]),
            .step   (step_q),
            .pos    (lane_pos[i]),
            .wrapped(lane_wrap[i])
        );
    end

    assign bus.obj_position = lane_pos;
    assign bus.wrapped      = lane_wrap;
    assign bus.game_time    = time_q;
    assign bus.step         = step_q;
    assign bus.game_state   = state_q;
endmodule

// File: tb/tb_obstacle_scroller.sv
// Directed bench: default-parameter scroller plus a fast-ramp, narrow-timer instance.
module tb_obstacle_scroller;
    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    obstacle_scroller_if #(.NUM_CH(4), .POS_W(10), .TIME_W(11)) bus_a ();
    obstacle_scroller_if #(.NUM_CH(4), .POS_W(10), .TIME_W(4))  bus_b ();

    obstacle_scroller dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    obstacle_scroller #(.TIME_W(4), .LEVEL_TICKS(4)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    typedef struct {
        logic       menu, won, lost, pau, tk, rst;
        logic [3:0] rcnt;
        logic [1:0] st;
        int         p0, p2, gt, stp;
        logic [3:0] wr;
    } vec_t;

    vec_t tbl [21];

    function automatic vec_t mk(input logic menu, won, lost, pau, tk, rst, input logic [3:0] rcnt,
                                input logic [1:0] st, input int p0, p2, gt, stp, input logic [3:0] wr);
        vec_t v;
        v.menu = menu; v.won = won; v.lost = lost; v.pau = pau; v.tk = tk; v.rst = rst;
        v.rcnt = rcnt; v.st = st; v.p0 = p0; v.p2 = p2; v.gt = gt; v.stp = stp; v.wr = wr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [9:0] pos_a(input int i);
        return bus_a.obj_position[i*10 +: 10];
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic menu, won, lost, pau, tk, input logic [3:0] rcnt);
        bus_a.menuScreen = menu; bus_a.playerWon = won; bus_a.playerLost = lost;
        bus_a.pause = pau; bus_a.tick = tk; bus_a.reset_obj_count = rcnt;
    endtask

    task automatic drive_b(input logic menu, won, lost, pau, tk);
        bus_b.menuScreen = menu; bus_b.playerWon = won; bus_b.playerLost = lost;
        bus_b.pause = pau; bus_b.tick = tk; bus_b.reset_obj_count = 4'b0000;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_wr, exp_stp, exp_gt;
        // Rows start from RUN at game_time=40: p0=200, p2=540.
        tbl[0]  = mk(0,0,0,1,1,0,4'b0000, 2'd2, 200, 540, 40, 5, 4'b0);
        tbl[1]  = mk(0,0,0,1,1,0,4'b0000, 2'd2, 200, 540, 40, 5, 4'b0);
        tbl[2]  = mk(0,0,0,1,1,0,4'b0000, 2'd2, 200, 540, 40, 5, 4'b0);
        tbl[3]  = mk(0,0,0,0,1,0,4'b0000, 2'd1, 200, 540, 40, 5, 4'b0);
        tbl[4]  = mk(0,0,0,0,1,0,4'b0000, 2'd1, 205, 545, 41, 5, 4'b0);
        tbl[5]  = mk(0,0,0,0,0,0,4'b0000, 2'd1, 205, 545, 41, 5, 4'b0);
        tbl[6]  = mk(0,0,0,0,1,0,4'b0100, 2'd1, 210,   0, 42, 5, 4'b0);
        tbl[7]  = mk(0,0,0,0,1,0,4'b0000, 2'd1, 215,   5, 43, 5, 4'b0);
        tbl[8]  = mk(0,0,1,1,1,0,4'b0000, 2'd3, 215,   5, 43, 5, 4'b0);
        tbl[9]  = mk(0,0,0,1,1,0,4'b0000, 2'd3, 215,   5, 43, 5, 4'b0);
        tbl[10] = mk(0,0,0,0,1,0,4'b0000, 2'd3, 215,   5, 43, 5, 4'b0);
        tbl[11] = mk(0,1,0,0,1,0,4'b0000, 2'd3, 215,   5, 43, 5, 4'b0);
        tbl[12] = mk(1,1,0,0,0,0,4'b0000, 2'd0,   0, 340,  0, 5, 4'b0);
        tbl[13] = mk(0,0,0,0,1,0,4'b0000, 2'd1,   0, 340,  0, 5, 4'b0);
        tbl[14] = mk(0,0,0,0,1,0,4'b0000, 2'd1,   5, 345,  1, 5, 4'b0);
        tbl[15] = mk(0,0,0,0,1,1,4'b0000, 2'd0,   0, 340,  0, 5, 4'b0);
        tbl[16] = mk(0,0,0,0,1,1,4'b0000, 2'd0,   0, 340,  0, 5, 4'b0);
        tbl[17] = mk(0,0,0,0,1,0,4'b0000, 2'd1,   0, 340,  0, 5, 4'b0);
        tbl[18] = mk(0,0,0,1,1,0,4'b0000, 2'd2,   0, 340,  0, 5, 4'b0);
        tbl[19] = mk(0,0,1,1,0,0,4'b0000, 2'd3,   0, 340,  0, 5, 4'b0);
        tbl[20] = mk(1,0,0,0,0,0,4'b0000, 2'd0,   0, 340,  0, 5, 4'b0);

        reset = 1'b1;
        drive_a(1, 0, 0, 0, 0, 4'b0000);
        drive_b(1, 0, 0, 0, 0);
        repeat (3) cyc();
        check("rst_state", bus_a.game_state, 0);
        check("rst_p0", pos_a(0), 0);
        check("rst_p1", pos_a(1), 170);
        check("rst_p2", pos_a(2), 340);
        check("rst_p3", pos_a(3), 510);
        check("rst_time", bus_a.game_time, 0);
        check("rst_step", bus_a.step, 5);
        check("rst_wrapped", bus_a.wrapped, 0);
        check("rst_state_b", bus_b.game_state, 0);

        // Continuous ticking: lane wraps, step ramp at tick 256, overshoot wrap.
        reset = 1'b0;
        drive_a(0, 0, 0, 0, 1, 4'b0000);
        cyc();
        check("idle_to_run_state", bus_a.game_state, 1);
        check("idle_to_run_noadv", pos_a(0), 0);
        for (int k = 1; k <= 300; k++) begin
            cyc();
            if (k <= 138) begin
                exp_wr = (k == 35) ? 8 : (k == 69) ? 4 : (k == 103) ? 2 : (k == 137) ? 1 : 0;
                check("run_p0", pos_a(0), (k <= 136) ? 5*k : (k == 137) ? 0 : 5);
                check("run_wrapped", bus_a.wrapped, exp_wr);
            end
            if (k == 102) check("lane1_at_limit", pos_a(1), 680);
            if (k == 103) check("lane1_wrapped", pos_a(1), 0);
            if (k == 138) check("time_138", bus_a.game_time, 138);
            if (k == 255) check("step_before_ramp", bus_a.step, 5);
            if (k == 256) begin
                check("step_after_ramp", bus_a.step, 6);
                check("ramp_uses_old_step", pos_a(0), 595);
            end
            if (k == 257) check("new_step_used", pos_a(0), 601);
            if (k == 271) check("overshoot", pos_a(0), 685);
            if (k == 272) begin
                check("overshoot_wrap", pos_a(0), 0);
                check("overshoot_wrap_flag", bus_a.wrapped[0], 1);
            end
        end
        check("time_300", bus_a.game_time, 300);
        check("p0_300", pos_a(0), 168);

        // Game over at 300 freezes the score across further ticks.
        drive_a(0, 0, 1, 0, 1, 4'b0000);
        cyc();
        check("over_state", bus_a.game_state, 3);
        drive_a(0, 0, 0, 1, 1, 4'b0000);
        for (int k = 0; k < 50; k++) begin
            cyc();
            check("over_time_frozen", bus_a.game_time, 300);
        end
        check("over_p0_frozen", pos_a(0), 168);
        check("over_step_frozen", bus_a.step, 6);
        check("over_state_held", bus_a.game_state, 3);
        drive_a(1, 0, 0, 0, 1, 4'b0000);
        cyc();
        check("menu_state", bus_a.game_state, 0);
        check("menu_p2", pos_a(2), 340);
        check("menu_time", bus_a.game_time, 0);
        check("menu_step", bus_a.step, 5);

        drive_a(0, 0, 0, 0, 1, 4'b0000);
        repeat (41) cyc();
        check("t40_time", bus_a.game_time, 40);
        check("t40_p0", pos_a(0), 200);
        check("t40_p3", pos_a(3), 25);

        for (int r = 0; r < 21; r++) begin
            reset = tbl[r].rst;
            drive_a(tbl[r].menu, tbl[r].won, tbl[r].lost, tbl[r].pau, tbl[r].tk, tbl[r].rcnt);
            cyc();
            check($sformatf("row%0d_state", r), bus_a.game_state, tbl[r].st);
            check($sformatf("row%0d_p0", r), pos_a(0), tbl[r].p0);
            check($sformatf("row%0d_p2", r), pos_a(2), tbl[r].p2);
            check($sformatf("row%0d_time", r), bus_a.game_time, tbl[r].gt);
            check($sformatf("row%0d_step", r), bus_a.step, tbl[r].stp);
            check($sformatf("row%0d_wrapped", r), bus_a.wrapped, tbl[r].wr);
        end
        reset = 1'b0;

        // Fast ramp to saturation and a 4-bit saturating timer.
        drive_b(0, 0, 0, 0, 1);
        cyc();
        check("b_run", bus_b.game_state, 1);
        for (int k = 1; k <= 50; k++) begin
            cyc();
            exp_stp = (5 + k/4 > 15) ? 15 : 5 + k/4;
            exp_gt  = (k > 15) ? 15 : k;
            check("b_step", bus_b.step, exp_stp);
            check("b_time", bus_b.game_time, exp_gt);
        end
        drive_b(1, 1, 0, 0, 1);
        cyc();
        check("b_won_menu_state", bus_b.game_state, 0);
        check("b_won_menu_time", bus_b.game_time, 0);
        check("b_won_menu_step", bus_b.step, 5);
        drive_b(0, 0, 0, 0, 1);
        cyc();
        check("b_rerun", bus_b.game_state, 1);
        drive_b(0, 1, 1, 0, 1);
        cyc();
        check("b_both_over", bus_b.game_state, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
